// File: rtl/mc_pkg.sv
// Shared definitions for the multicore memory controller load/store paths.
package mc_pkg;

   localparam int unsigned NUM_CORES    = 4;
   localparam int unsigned DEF_NUM_ROWS = 16;
   localparam int unsigned DEF_ADDR_W   = 4;
   localparam int unsigned STATE_W      = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_START = 3'd4
   } load_state_e;

endpackage

// File: rtl/load_row_decoder.sv
// Row address to one-hot row select with enable; shared by load and store paths.
module load_row_decoder
   import mc_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic                 en,
   input  logic [ADDR_W-1:0]    addr,
   output logic [2**ADDR_W-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[addr] = 1'b1;
   end

endmodule

// File: rtl/load_controller.sv
// Load sequencer: reads every data-memory row in order, routes it through the
// switch into the register bank, then pulses start to all cores.
module load_controller
   import mc_pkg::*;
#(
   parameter int unsigned NUM_ROWS = DEF_NUM_ROWS,
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter int unsigned MEM_LAT  = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 loadReq,
   output logic                 memRead,
   output logic [ADDR_W-1:0]    rowaddr,
   output logic                 swEnable,
   output logic [2**ADDR_W-1:0] rowaddrtoSw,
   output logic                 memRdtoReg,
   output logic [NUM_CORES-1:0] coreStart,
   output logic                 busy,
   output logic                 loadDone
);

   localparam int unsigned LAT_W = 3;
   localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(NUM_ROWS - 1);
   // WAIT spans MEM_LAT-1 cycles, so the counter starts one below that.
   localparam logic [LAT_W-1:0]  LAT_LOAD = (MEM_LAT >= 2) ? LAT_W'(MEM_LAT - 2) : '0;

   load_state_e       state;
   load_state_e       state_nxt;
   logic [ADDR_W-1:0] row;
   logic [LAT_W-1:0]  lat_cnt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (loadReq) state_nxt = ST_READ;
         ST_READ:  state_nxt = (MEM_LAT == 1) ? ST_WRITE : ST_WAIT;
         ST_WAIT:  if (lat_cnt == '0) state_nxt = ST_WRITE;
         ST_WRITE: state_nxt = (row == ROW_LAST) ? ST_START : ST_READ;
         ST_START: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Row and latency counters; row never wraps, it stops at ROW_LAST
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row     <= '0;
         lat_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE:  if (loadReq) row <= '0;
            ST_READ:  lat_cnt <= LAT_LOAD;
            ST_WAIT:  if (lat_cnt != '0) lat_cnt <= lat_cnt - LAT_W'(1);
            ST_WRITE: if (row != ROW_LAST) row <= row + ADDR_W'(1);
            ST_START: row <= '0;
            default:  row <= '0;
         endcase
      end
   end

   // Output decode from registered state only, so strobes are glitch-free
   always_comb begin
      memRead    = 1'b0;
      swEnable   = 1'b0;
      memRdtoReg = 1'b0;
      coreStart  = '0;
      loadDone   = 1'b0;
      busy       = (state != ST_IDLE);
      case (state)
         ST_READ: begin
            memRead  = 1'b1;
            swEnable = 1'b1;
         end
         ST_WAIT:  swEnable = 1'b1;
         ST_WRITE: begin
            memRdtoReg = 1'b1;
            swEnable   = 1'b1;
         end
         ST_START: begin
            coreStart = '1;
            loadDone  = 1'b1;
         end
         default: ;
      endcase
   end

   assign rowaddr = row;

   load_row_decoder #(.ADDR_W(ADDR_W)) u_row_dec (
      .en     (swEnable),
      .addr   (row),
      .onehot (rowaddrtoSw)
   );

endmodule

// File: tb/tb_load_controller.sv
// Scoreboard bench for load_controller: default instance and a MEM_LAT=3, 4-row instance.
module tb_load_controller;

   typedef struct packed {
      logic        mem_read;
      logic [3:0]  rowaddr;
      logic        sw_en;
      logic [15:0] onehot;
      logic        rd_to_reg;
      logic [3:0]  core_start;
      logic        busy;
      logic        load_done;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        load_req0, load_req1;

   logic        mem_read0, sw_en0, rd_to_reg0, busy0, done0;
   logic [3:0]  rowaddr0, cstart0;
   logic [15:0] onehot0;
   logic        mem_read1, sw_en1, rd_to_reg1, busy1, done1;
   logic [3:0]  rowaddr1, cstart1;
   logic [15:0] onehot1;

   int unsigned passed = 0;
   int unsigned total  = 0;
   obs_t        exp_q[$];

   always #5 clk = ~clk;

   load_controller dut (
      .clk(clk), .rst_n(rst_n), .loadReq(load_req0),
      .memRead(mem_read0), .rowaddr(rowaddr0), .swEnable(sw_en0),
      .rowaddrtoSw(onehot0), .memRdtoReg(rd_to_reg0), .coreStart(cstart0),
      .busy(busy0), .loadDone(done0)
   );

   load_controller #(.NUM_ROWS(4), .ADDR_W(4), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .loadReq(load_req1),
      .memRead(mem_read1), .rowaddr(rowaddr1), .swEnable(sw_en1),
      .rowaddrtoSw(onehot1), .memRdtoReg(rd_to_reg1), .coreStart(cstart1),
      .busy(busy1), .loadDone(done1)
   );

   function automatic obs_t observe(input bit sel);
      obs_t o;
      if (!sel) o = '{mem_read0, rowaddr0, sw_en0, onehot0, rd_to_reg0, cstart0, busy0, done0};
      else      o = '{mem_read1, rowaddr1, sw_en1, onehot1, rd_to_reg1, cstart1, busy1, done1};
      return o;
   endfunction

   task automatic push_idle(input int n);
      obs_t e;
      e = '0;
      for (int i = 0; i < n; i++) exp_q.push_back(e);
   endtask

   // Expected per-cycle outputs of one complete load, from the first READ cycle to START.
   task automatic push_load(input int lat, input int rows);
      obs_t e;
      for (int r = 0; r < rows; r++) begin
         e = '0;
         e.rowaddr = 4'(r);
         e.sw_en   = 1'b1;
         e.onehot  = 16'h0001 << r;
         e.busy    = 1'b1;
         e.mem_read = 1'b1;
         exp_q.push_back(e);
         e.mem_read = 1'b0;
         for (int w = 0; w < lat - 1; w++) exp_q.push_back(e);
         e.rd_to_reg = 1'b1;
         exp_q.push_back(e);
      end
      e = '0;
      e.rowaddr    = 4'(rows - 1);
      e.core_start = 4'hF;
      e.busy       = 1'b1;
      e.load_done  = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      obs_t o, e;
      rst_n = 1'b0;
      load_req0 = 1'b0;
      load_req1 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         o = observe(0);
         total++;
         if (o !== '0) $display("FAIL reset_dut cyc %0d got %h want 0", c, o);
         else passed++;
         o = observe(1);
         total++;
         if (o !== '0) $display("FAIL reset_dut3 cyc %0d got %h want 0", c, o);
         else passed++;
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      push_idle(10);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(0);
         total++;
         if (o !== e) $display("FAIL idle cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_full_load();
      obs_t o, e;
      int n;
      push_idle(1);
      push_load(1, 16);
      push_idle(3);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         load_req0 = (c == 0);
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(0);
         total++;
         if (o !== e) $display("FAIL full_load cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
      load_req0 = 1'b0;
   endtask

   task automatic test_latency3();
      obs_t o, e;
      int n;
      push_idle(1);
      push_load(3, 4);
      push_idle(3);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         load_req1 = (c == 0);
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(1);
         total++;
         if (o !== e) $display("FAIL latency3 cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
      load_req1 = 1'b0;
   endtask

   task automatic test_busy_request();
      obs_t o, e;
      int n;
      push_idle(1);
      push_load(1, 16);
      push_idle(5);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         load_req0 = (c == 0) || (c == 5) || (c == 20);
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(0);
         total++;
         if (o !== e) $display("FAIL busy_req cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
      load_req0 = 1'b0;
   endtask

   task automatic test_reset_midload();
      obs_t o, e;
      int n;
      push_idle(1);
      push_load(1, 16);
      while (exp_q.size() > 10) void'(exp_q.pop_back());
      push_idle(6);
      push_load(1, 16);
      push_idle(2);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         load_req0 = (c == 0) || (c == 15);
         rst_n     = (c != 10);
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(0);
         total++;
         if (o !== e) $display("FAIL reset_midload cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
      rst_n     = 1'b1;
      load_req0 = 1'b0;
   endtask

   task automatic test_back_to_back();
      obs_t o, e;
      int n;
      push_idle(1);
      push_load(1, 16);
      push_idle(1);
      push_load(1, 16);
      push_idle(3);
      n = exp_q.size();
      for (int c = 0; c < n; c++) begin
         load_req0 = (c < 68);
         @(negedge clk);
         e = exp_q.pop_front();
         o = observe(0);
         total++;
         if (o !== e) $display("FAIL back_to_back cyc %0d got %h want %h", c, o, e);
         else passed++;
         @(posedge clk); #1;
      end
      load_req0 = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      load_req0 = 1'b0;
      load_req1 = 1'b0;
      test_reset();
      test_full_load();
      test_latency3();
      test_busy_request();
      test_reset_midload();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/load_controller.md
Name: load_controller

Overview:
- Memory-to-register load sequencer for the multicore memory controller; the read-side counterpart of the store path.
- On a load request it reads every data-memory row in order and routes each row through the crossbar switch into the core register bank.
- When all rows are loaded it pulses a start signal to all four cores.
- Sits between the host/top-level start logic, data memory, the crossbar switch and the four cores.

Parameters:
NUM_ROWS, 16, number of memory rows to load (2..16)
ADDR_W, 4, row address width; must satisfy 2**ADDR_W >= NUM_ROWS
MEM_LAT, 1, data-memory read latency in cycles (1..7)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
loadReq  input  1  request to start a full load; sampled only in IDLE
memRead  output  1  read strobe to data memory
rowaddr  output  ADDR_W  current row address (to data memory and registers)
swEnable  output  1  switch enable; memory-to-register routing active
rowaddrtoSw  output  2**ADDR_W  one-hot row select to switch
memRdtoReg  output  1  write memory data into the selected register row
coreStart  output  4  per-core operation start pulse (bit i = core i+1)
busy  output  1  high whenever state is not IDLE
loadDone  output  1  one-cycle pulse, coincident with coreStart

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE, row=0, lat counter=0. All outputs 0 except rowaddr=0.
- A reset mid-load aborts immediately. No coreStart is issued. A fresh loadReq is required afterwards.
- States: IDLE, READ, WAIT, WRITE, START.
- IDLE:
  - With loadReq=1: row<=0, go to READ next cycle. Latency from loadReq to first memRead is 1 cycle.
  - With loadReq=0: stay in IDLE.
- READ (1 cycle):
  - memRead=1, swEnable=1.
  - If MEM_LAT==1, go to WRITE. Otherwise load counter with MEM_LAT-2 and go to WAIT.
- WAIT:
  - memRead=0, swEnable=1.
  - Decrement the counter. Go to WRITE when the counter is 0.
  - WAIT lasts exactly MEM_LAT-1 cycles.
- WRITE (1 cycle):
  - memRdtoReg=1, swEnable=1. Data read in READ is valid exactly this cycle.
  - If row==NUM_ROWS-1, go to START. Otherwise row<=row+1 and go to READ.
- START (1 cycle):
  - coreStart=4'b1111, loadDone=1, swEnable=0, then go to IDLE.
  - row<=0 on entry to IDLE.
- rowaddr = row register in all states. It is stable throughout READ/WAIT/WRITE of a row.
- rowaddrtoSw = one-hot decode of row when swEnable=1, else all zeros. Combinational from registered state/row, glitch-free.
- memRead, memRdtoReg and coreStart are never high in the same cycle.
- Per-row cost is MEM_LAT+1 cycles. A full load takes NUM_ROWS*(MEM_LAT+1) cycles, plus 1 START cycle, after the IDLE->READ transition. The default is 33 cycles.
- loadReq while busy=1 is ignored and not queued. loadReq held high in the START cycle is ignored. loadReq held high into the following IDLE cycle starts a new load.
- The row counter never wraps. Termination is by comparison with NUM_ROWS-1; rows >= NUM_ROWS are never addressed.

Decomposition:
- Shared package/header (mc_pkg) holds:
  - state encodings (IDLE=0, READ=1, WAIT=2, WRITE=3, START=4, 3-bit);
  - NUM_CORES=4;
  - the default NUM_ROWS and ADDR_W, shared with the store path.
- One sub-module: load_row_decoder (ADDR_W to 2**ADDR_W one-hot with enable). The store side can reuse it.
- The FSM, row counter and latency counter stay in load_controller.

Test Plan:
- Reset then idle: rst_n low for 3 cycles, loadReq=0 for 10 cycles -> all outputs 0, busy=0, rowaddr=0.
- Full load, defaults: one-cycle loadReq pulse at cycle 0 ->
  - memRead high at cycles 1,3,...,31 with rowaddr 0..15;
  - memRdtoReg high at cycles 2,4,...,32, with rowaddrtoSw=16'h0001<<row;
  - coreStart=4'b1111 and loadDone at cycle 33, only;
  - busy high for cycles 1..33.
- Latency 3 (MEM_LAT=3, NUM_ROWS=4): one loadReq pulse ->
  - memRead at cycles 1,5,9,13;
  - memRdtoReg at cycles 4,8,12,16;
  - WAIT visible 2 cycles per row;
  - coreStart at cycle 17.
- Request while busy: loadReq re-pulsed at cycles 5 and 20 of a default load -> sequence identical to the full-load case; no second load afterwards.
- Reset mid-load: rst_n low at cycle 10 for 1 cycle ->
  - outputs 0 asynchronously in that cycle;
  - no coreStart ever;
  - a subsequent loadReq restarts at rowaddr=0.
- Back-to-back: loadReq held high continuously -> loads repeat with one IDLE cycle between START and the next READ; coreStart every 34 cycles.
